// File: rtl/dev_timer.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot or auto-reload interrupt.
// Latency: reads are combinational, writes land at the next edge; no backpressure, the bus is never stalled.
module dev_timer #(
  parameter logic [31:0] RST_PRESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iSel,
  input  logic        iWE,
  input  logic [1:0]  iAddr,
  input  logic [3:0]  iBE,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oIRQ
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  stateNext;
  logic        ctrlEn;
  logic [1:0]  ctrlMode;
  logic        ctrlIm;
  logic [31:0] preset;
  logic [31:0] count;
  logic        pending;

  logic        wrCtrl;
  logic        wrPreset;
  logic        wrEn;
  logic [1:0]  wrMode;
  logic        wrIm;
  logic [31:0] presetMerged;
  logic        countZero;
  logic        isReload;
  logic        reachZero;

  assign wrCtrl    = iSel & iWE & (iAddr == ADDR_CTRL);
  assign wrPreset  = iSel & iWE & (iAddr == ADDR_PRESET);
  assign countZero = (count == 32'd0);
  assign isReload  = (ctrlMode == MODE_RELOAD);
  assign reachZero = (state == CNT) & ctrlEn & countZero;

  // All CTRL fields live in byte lane 0; a write without that lane keeps the old fields.
  assign wrEn   = iBE[0] ? iData[0]   : ctrlEn;
  assign wrMode = iBE[0] ? iData[2:1] : ctrlMode;
  assign wrIm   = iBE[0] ? iData[3]   : ctrlIm;

  always_comb begin
    presetMerged = preset;
    for (int i = 0; i < 4; i++) begin
      if (iBE[i]) begin
        presetMerged[8*i +: 8] = iData[8*i +: 8];
      end
    end
  end

  // A CTRL write landing in INT overrides the mode-driven choice of next state.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (ctrlEn) begin
          stateNext = LOAD;
        end
      end
      LOAD: begin
        stateNext = CNT;
      end
      CNT: begin
        if (!ctrlEn) begin
          stateNext = IDLE;
        end else if (countZero) begin
          stateNext = INT;
        end
      end
      INT: begin
        if (wrCtrl) begin
          stateNext = wrEn ? LOAD : IDLE;
        end else begin
          stateNext = isReload ? LOAD : IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= 32'd0;
    end else begin
      state <= stateNext;
      if (state == LOAD) begin
        count <= preset;
      end else if ((state == CNT) && ctrlEn && !countZero) begin
        count <= count - 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrlEn   <= 1'b0;
      ctrlMode <= 2'b00;
      ctrlIm   <= 1'b0;
    end else if (wrCtrl) begin
      ctrlEn   <= wrEn;
      ctrlMode <= wrMode;
      ctrlIm   <= wrIm;
    end else if ((state == INT) && !isReload) begin
      ctrlEn <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset <= RST_PRESET;
    end else if (wrPreset) begin
      preset <= presetMerged;
    end
  end

  // Pending is raised on the same edge that enters INT so the interrupt appears with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
    end else if (reachZero) begin
      pending <= 1'b1;
    end else if (wrCtrl) begin
      pending <= 1'b0;
    end else if ((state == INT) && isReload) begin
      pending <= 1'b0;
    end
  end

  always_comb begin
    oData = 32'h0;
    case (iAddr)
      ADDR_CTRL:   oData = {28'h0, ctrlIm, ctrlMode, ctrlEn};
      ADDR_PRESET: oData = preset;
      ADDR_COUNT:  oData = count;
      default:     oData = 32'h0;
    endcase
  end

  assign oIRQ = pending & ctrlIm;

endmodule

// File: tb/tb_dev_timer.sv
// Directed plus randomized bench for dev_timer with an event-schedule reference model.
module tb_dev_timer;

  logic        clk;
  logic        reset;
  logic        iSel;
  logic        iWE;
  logic [1:0]  iAddr;
  logic [3:0]  iBE;
  logic [31:0] iData;
  logic [31:0] oData;
  logic        oIRQ;

  int testsRun = 0;
  int failCnt  = 0;

  dev_timer dut (
    .clk   (clk),
    .reset (reset),
    .iSel  (iSel),
    .iWE   (iWE),
    .iAddr (iAddr),
    .iBE   (iBE),
    .iData (iData),
    .oData (oData),
    .oIRQ  (oIRQ)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference model: the timer is described by the edge numbers at which COUNT is loaded
  // and at which the interrupt fires, not by a state register.
  logic        mEn;
  logic        mIm;
  logic [1:0]  mMode;
  logic [31:0] mPreset;
  logic [31:0] mCount;
  logic [31:0] mLoaded;
  logic        mPending;
  logic        mRunning;
  longint      cyc;
  longint      loadEdge;
  longint      intEdge;

  task automatic modelReset();
    mEn = 1'b0; mIm = 1'b0; mMode = 2'b00;
    mPreset = 32'h0; mCount = 32'h0; mLoaded = 32'h0;
    mPending = 1'b0; mRunning = 1'b0;
  endtask

  task automatic modelEdge(input logic sel, input logic we, input logic [1:0] addr,
                           input logic [3:0] be, input logic [31:0] data);
    logic        oEn;
    logic [1:0]  oMode;
    logic [31:0] oPreset;
    logic        wc;
    logic        wEn;
    cyc++;
    oEn = mEn; oMode = mMode; oPreset = mPreset;
    wc  = sel && we && (addr == 2'd0);
    wEn = be[0] ? data[0] : mEn;
    if (wc) begin
      mPending = 1'b0;
      if (be[0]) {mIm, mMode, mEn} = data[3:0];
    end
    if (sel && we && (addr == 2'd1)) begin
      for (int i = 0; i < 4; i++) if (be[i]) mPreset[8*i +: 8] = data[8*i +: 8];
    end
    if (!mRunning) begin
      if (oEn) begin
        mRunning = 1'b1;
        loadEdge = cyc + 1;
        intEdge  = cyc + 1 + (64'd1 << 40);
      end
    end else if (cyc == loadEdge) begin
      mLoaded = oPreset;
      mCount  = oPreset;
      intEdge = cyc + longint'(oPreset) + 1;
    end else if (cyc <= intEdge) begin
      if (!oEn) mRunning = 1'b0;
      else if (cyc == intEdge) mPending = 1'b1;
      else mCount = mLoaded - 32'(cyc - loadEdge);
    end else begin
      if (oMode == 2'b01) mPending = 1'b0;
      else if (!wc) mEn = 1'b0;
      if (wc ? wEn : (oMode == 2'b01)) loadEdge = cyc + 1;
      else mRunning = 1'b0;
    end
  endtask

  function automatic logic [31:0] mRead(input logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, mIm, mMode, mEn};
      2'd1:    return mPreset;
      2'd2:    return mCount;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      failCnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic sel, input logic we, input logic [1:0] addr,
                      input logic [3:0] be, input logic [31:0] data, input logic [1:0] rd);
    @(negedge clk);
    iSel = sel; iWE = we; iAddr = addr; iBE = be; iData = data;
    @(posedge clk);
    modelEdge(sel, we, addr, be, data);
    #1;
    iSel = 1'b0; iWE = 1'b0; iBE = 4'h0; iData = 32'h0; iAddr = rd;
    #1;
    chk($sformatf("read_addr%0d_cyc%0d", rd, cyc), oData, mRead(rd));
    chk($sformatf("irq_cyc%0d", cyc), {31'h0, oIRQ}, {31'h0, mPending & mIm});
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    step(1'b1, 1'b1, addr, 4'hF, data, 2'd2);
  endtask

  task automatic idle(input logic [1:0] rd);
    step(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, rd);
  endtask

  // Called right after a step: the pulse sits entirely between a rising and falling edge.
  task automatic rstPulse();
    #1 reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      iAddr = 2'(a);
      #1 chk($sformatf("reset_addr%0d", a), oData, 32'h0);
    end
    chk("reset_irq", {31'h0, oIRQ}, 32'h0);
    modelReset();
    #1 reset = 1'b1;
  endtask

  int riseK;
  int rises[$];
  int highs;
  logic prevIrq;
  int r;
  logic [31:0] p;
  logic [1:0]  md;
  logic        im;

  initial begin
    reset = 1'b0; iSel = 1'b0; iWE = 1'b0; iAddr = 2'd0; iBE = 4'h0; iData = 32'h0;
    cyc = 0; loadEdge = 0; intEdge = 0;
    modelReset();
    for (int a = 0; a < 4; a++) begin
      iAddr = 2'(a);
      #1 chk($sformatf("init_addr%0d", a), oData, 32'h0);
    end
    chk("init_irq", {31'h0, oIRQ}, 32'h0);
    reset = 1'b1;

    // One-shot: PRESET=5, CTRL=9; interrupt at E0+8, sticky, EN self-clears.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    riseK = -1;
    for (int k = 1; k <= 12; k++) begin
      idle(2'd2);
      if (oIRQ && riseK < 0) riseK = k;
    end
    chk("oneshot_rise_edge", 32'(riseK), 32'd8);
    chk("oneshot_irq_held", {31'h0, oIRQ}, 32'h1);
    idle(2'd0);
    chk("oneshot_ctrl", oData, 32'h8);

    // CTRL write clears pending; block stays idle with COUNT 0.
    wr(2'd0, 32'h0);
    chk("clear_irq", {31'h0, oIRQ}, 32'h0);
    for (int k = 0; k < 4; k++) idle(2'd2);
    chk("clear_count", oData, 32'h0);

    // Auto-reload: PRESET=2, CTRL=B -> one-cycle pulses every 5 cycles.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    rises.delete();
    highs = 0; prevIrq = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      idle(2'd2);
      if (oIRQ) highs++;
      if (oIRQ && !prevIrq) rises.push_back(k);
      prevIrq = oIRQ;
    end
    chk("reload_pulses", 32'(rises.size() >= 4), 32'h1);
    chk("reload_width", 32'(highs), 32'(rises.size()));
    if (rises.size() >= 4) begin
      chk("reload_first", 32'(rises[0]), 32'd5);
      for (int i = 1; i < 4; i++) chk($sformatf("reload_period%0d", i), 32'(rises[i] - rises[i-1]), 32'd5);
    end
    wr(2'd0, 32'h0);
    rstPulse();

    // PRESET rewrite mid-count only affects the next reload.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h3);
    for (int k = 0; k < 4; k++) idle(2'd2);
    step(1'b1, 1'b1, 2'd1, 4'b0001, 32'h3, 2'd1);
    chk("partial_preset", oData, 32'h3);
    for (int k = 0; k < 22; k++) idle(2'd2);
    wr(2'd0, 32'h0);
    for (int k = 0; k < 3; k++) idle(2'd2);
    rstPulse();

    // CTRL write during INT: EN=0 wins, then EN=1 restarts.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 4; k++) idle(2'd2);
    chk("collide_irq_in_int", {31'h0, oIRQ}, 32'h1);
    step(1'b1, 1'b1, 2'd0, 4'hF, 32'h0, 2'd0);
    chk("collide_ctrl", oData, 32'h0);
    chk("collide_irq", {31'h0, oIRQ}, 32'h0);
    for (int k = 0; k < 3; k++) idle(2'd2);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 4; k++) idle(2'd2);
    step(1'b1, 1'b1, 2'd0, 4'hF, 32'h9, 2'd0);
    for (int k = 0; k < 8; k++) idle(2'd2);
    idle(2'd0);
    chk("restart_ctrl", oData, 32'h8);
    chk("restart_irq", {31'h0, oIRQ}, 32'h1);
    rstPulse();

    // IM=0: no interrupt; later CTRL write clears the hidden pending.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    for (int k = 0; k < 8; k++) idle(2'd0);
    chk("masked_ctrl", oData, 32'h0);
    chk("masked_irq", {31'h0, oIRQ}, 32'h0);
    step(1'b1, 1'b1, 2'd0, 4'hF, 32'h8, 2'd0);
    for (int k = 0; k < 3; k++) idle(2'd0);
    chk("masked_after_im", {31'h0, oIRQ}, 32'h0);

    // Reset mid-count aborts; nothing happens until EN is written again.
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 10 && mCount != 32'd7; k++) idle(2'd2);
    chk("abort_count_before", oData, 32'd7);
    rstPulse();
    for (int k = 0; k < 6; k++) idle(2'd2);
    chk("abort_count_after", oData, 32'h0);

    // Randomized trials with bus noise.
    for (int t = 0; t < 12; t++) begin
      p  = $urandom_range(0, 12);
      md = 2'($urandom_range(0, 3));
      im = 1'($urandom_range(0, 1));
      wr(2'd1, p);
      wr(2'd0, {28'h0, im, md, 1'b1});
      for (int k = 0; k < 3 * (int'(p) + 3) + 4; k++) begin
        r = $urandom_range(0, 9);
        if (r < 2) step(1'b1, 1'b1, 2'(2 + $urandom_range(0, 1)), 4'($urandom), $urandom, 2'($urandom_range(0, 3)));
        else if (r < 3) step(1'b1, 1'b1, 2'd1, 4'($urandom), $urandom_range(0, 6), 2'($urandom_range(0, 3)));
        else if (r < 4) step(1'b0, 1'b1, 2'($urandom_range(0, 1)), 4'hF, $urandom, 2'($urandom_range(0, 3)));
        else idle(2'($urandom_range(0, 3)));
      end
      rstPulse();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end

endmodule
